// File: rtl/rr_mux_n.sv
// rr_mux_n: N-to-1 round-robin / fixed-select data mux with a registered valid/ready output stage.
// Optional packet locking (hold a channel until its in_last beat) is enabled by MUX_PKT_LOCK_EN.
module rr_mux_n #(
    parameter  int NUM_CH = 4,
    parameter  int WIDTH  = 8,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH-1:0]       in_last,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    force_en,
    input  logic [CH_W-1:0]         force_sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_last,
    output logic [CH_W-1:0]         out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam logic [CH_W:0]   NUM_CH_X = (CH_W + 1)'(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

    logic [CH_W-1:0]  rr_ptr_r;
    logic [CH_W-1:0]  rr_grant_s;
    logic             rr_grant_vld_s;
    logic [CH_W:0]    scan_sum_s;
    logic [CH_W-1:0]  scan_idx_s;
    logic             force_in_range_s;
    logic             force_vld_s;
    logic [CH_W-1:0]  grant_s;
    logic             grant_vld_s;
    logic             load_s;
    logic             accept_s;
    logic [WIDTH-1:0] sel_data_s;
    logic             sel_last_s;
    logic [CH_W-1:0]  ptr_next_s;
    logic             ptr_upd_s;

`ifdef MUX_PKT_LOCK_EN
    logic             lock_r;
    logic [CH_W-1:0]  lock_ch_r;
`endif

    // Round-robin scan: walk offsets from farthest to nearest so the channel closest to rr_ptr wins.
    always_comb begin
        rr_grant_s     = {CH_W{1'b0}};
        rr_grant_vld_s = 1'b0;
        scan_sum_s     = {(CH_W + 1){1'b0}};
        scan_idx_s     = {CH_W{1'b0}};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            scan_sum_s = {1'b0, rr_ptr_r} + (CH_W + 1)'(i);
            scan_sum_s = (scan_sum_s >= NUM_CH_X) ? (scan_sum_s - NUM_CH_X) : scan_sum_s;
            scan_idx_s = scan_sum_s[CH_W-1:0];
            if (in_valid[scan_idx_s]) begin
                rr_grant_s     = scan_idx_s;
                rr_grant_vld_s = 1'b1;
            end else begin
                rr_grant_s     = rr_grant_s;
                rr_grant_vld_s = rr_grant_vld_s;
            end
        end
    end

    // With a power-of-two channel count every force_sel encoding is a real channel.
    generate
        if ((1 << CH_W) == NUM_CH) begin : g_sel_full
            assign force_in_range_s = 1'b1;
        end else begin : g_sel_partial
            assign force_in_range_s = ({1'b0, force_sel} < NUM_CH_X);
        end
    endgenerate

    assign force_vld_s = force_in_range_s && in_valid[force_sel];

    // Grant source priority: packet lock (if built in), then force mode, then round robin.
    always_comb begin
        grant_s     = {CH_W{1'b0}};
        grant_vld_s = 1'b0;
`ifdef MUX_PKT_LOCK_EN
        if (lock_r) begin
            grant_s     = lock_ch_r;
            grant_vld_s = in_valid[lock_ch_r];
        end else if (force_en) begin
            grant_s     = force_sel;
            grant_vld_s = force_vld_s;
        end else begin
            grant_s     = rr_grant_s;
            grant_vld_s = rr_grant_vld_s;
        end
`else
        if (force_en) begin
            grant_s     = force_sel;
            grant_vld_s = force_vld_s;
        end else begin
            grant_s     = rr_grant_s;
            grant_vld_s = rr_grant_vld_s;
        end
`endif
    end

    assign load_s     = !out_valid || out_ready;
    assign accept_s   = rst_n && load_s && grant_vld_s;
    assign sel_data_s = in_data[grant_s*WIDTH +: WIDTH];
    assign sel_last_s = in_last[grant_s];
    assign ptr_next_s = (grant_s == LAST_CH) ? {CH_W{1'b0}} : (grant_s + CH_W'(1));

`ifdef MUX_PKT_LOCK_EN
    // A locked packet only releases the arbiter on its final beat.
    assign ptr_upd_s = accept_s && sel_last_s;
`else
    assign ptr_upd_s = accept_s;
`endif

    // One-hot ready toward the granted producer; held low during reset through accept_s.
    always_comb begin
        in_ready = {NUM_CH{1'b0}};
        if (accept_s) begin
            in_ready[grant_s] = 1'b1;
        end else begin
            in_ready = {NUM_CH{1'b0}};
        end
    end

    // Output stage: capture on accept, drain when consumed with nothing new, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= {WIDTH{1'b0}};
            out_last  <= 1'b0;
            out_ch    <= {CH_W{1'b0}};
        end else if (accept_s) begin
            out_valid <= 1'b1;
            out_data  <= sel_data_s;
            out_last  <= sel_last_s;
            out_ch    <= grant_s;
        end else if (load_s) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

    // Round-robin pointer moves just past the channel that was served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= {CH_W{1'b0}};
        end else if (ptr_upd_s) begin
            rr_ptr_r <= ptr_next_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

`ifdef MUX_PKT_LOCK_EN
    // Packet lock: a non-final beat pins the arbiter to its channel until in_last is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_r    <= 1'b0;
            lock_ch_r <= {CH_W{1'b0}};
        end else if (accept_s) begin
            lock_r    <= !sel_last_s;
            lock_ch_r <= grant_s;
        end else begin
            lock_r    <= lock_r;
            lock_ch_r <= lock_ch_r;
        end
    end
`endif

endmodule
